// File: rtl/branch_predictor.sv
// Set-associative BTB with per-entry saturating direction counters.
// Lookup results are registered; updates resolve hit/allocate in one cycle.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  lookup_valid,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_trgt,
    input  logic                  update_valid,
    input  logic [DATA_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [DATA_WIDTH-1:0] update_trgt,
    output logic                  ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   sweep_idx_q;
    logic               pred_valid_q, pred_hit_q, pred_taken_q;
    logic [DATA_WIDTH-1:0] pred_trgt_q;

    logic [WAYS-1:0]       valid_q  [SETS];
    logic [TAG_W-1:0]      tag_q    [SETS][WAYS];
    logic [DATA_WIDTH-1:0] trgt_q   [SETS][WAYS];
    logic [CTR_BITS-1:0]   ctr_q    [SETS][WAYS];
    logic [PTR_W-1:0]      victim_q [SETS];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic [WAYS-1:0]  lk_match, up_match;
    logic unused_pc_bits;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[DATA_WIDTH-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[DATA_WIDTH-1:IDX_W+2];
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
        assign lk_match[gi] = valid_q[lk_idx][gi] && (tag_q[lk_idx][gi] == lk_tag);
        assign up_match[gi] = valid_q[up_idx][gi] && (tag_q[up_idx][gi] == up_tag);
    end

    logic                  lk_hit, lk_taken;
    logic [DATA_WIDTH-1:0] lk_trgt;

    always_comb begin
        lk_hit   = |lk_match;
        lk_taken = 1'b0;
        lk_trgt  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_match[w]) begin
                lk_taken = ctr_q[lk_idx][w][CTR_BITS-1];
                lk_trgt  = trgt_q[lk_idx][w];
            end
        end
    end

    logic                up_hit, free_found;
    logic [PTR_W-1:0]    up_way, free_way, alloc_way, victim_next;
    logic [CTR_BITS-1:0] cur_ctr, ctr_next;

    // Downward scan leaves the lowest-numbered invalid way in free_way.
    always_comb begin
        up_hit     = |up_match;
        up_way     = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (up_match[w]) up_way = PTR_W'(w);
            if (!valid_q[up_idx][w]) begin
                free_found = 1'b1;
                free_way   = PTR_W'(w);
            end
        end
        alloc_way   = free_found ? free_way : victim_q[up_idx];
        victim_next = (victim_q[up_idx] == PTR_W'(WAYS - 1)) ? '0 : victim_q[up_idx] + 1'b1;
        cur_ctr     = ctr_q[up_idx][up_way];
        if (update_taken) ctr_next = (cur_ctr == '1) ? cur_ctr : cur_ctr + 1'b1;
        else              ctr_next = (cur_ctr == '0) ? cur_ctr : cur_ctr - 1'b1;
    end

    logic run_ok, do_hit, do_alloc;
    assign run_ok   = (state_q == RUN) && !rst && !flush;
    assign do_hit   = run_ok && update_valid && up_hit;
    assign do_alloc = run_ok && update_valid && !up_hit && update_taken;

    // Storage has no reset: the sweep clears valid bits and victim pointers.
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) begin
            valid_q[sweep_idx_q]  <= '0;
            victim_q[sweep_idx_q] <= '0;
        end
        if (do_hit) begin
            ctr_q[up_idx][up_way] <= ctr_next;
            if (update_taken) trgt_q[up_idx][up_way] <= update_trgt;
        end
        if (do_alloc) begin
            valid_q[up_idx][alloc_way] <= 1'b1;
            tag_q[up_idx][alloc_way]   <= up_tag;
            trgt_q[up_idx][alloc_way]  <= update_trgt;
            ctr_q[up_idx][alloc_way]   <= CTR_INIT;
            if (!free_found) victim_q[up_idx] <= victim_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SWEEP;
            sweep_idx_q  <= '0;
            pred_valid_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_trgt_q  <= '0;
        end else begin
            if (flush) begin
                state_q     <= SWEEP;
                sweep_idx_q <= '0;
            end else if (state_q == SWEEP) begin
                sweep_idx_q <= sweep_idx_q + 1'b1;
                if (sweep_idx_q == IDX_W'(SETS - 1)) state_q <= RUN;
            end
            pred_valid_q <= run_ok && lookup_valid;
            if (run_ok && lookup_valid) begin
                pred_hit_q   <= lk_hit;
                pred_taken_q <= lk_taken;
                pred_trgt_q  <= lk_trgt;
            end
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_hit   = pred_hit_q;
    assign pred_taken = pred_taken_q;
    assign pred_trgt  = pred_trgt_q;
    assign ready      = (state_q == RUN);

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor; a scoreboard queue holds
// the expected outputs per cycle, computed from an entry-list reference model.
module tb_branch_predictor;

    localparam int DW    = 32;
    localparam int SETS  = 16;
    localparam int WAYS  = 2;
    localparam int CB    = 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int CMAX  = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1, flush = 1'b0;
    logic          lookup_valid = 1'b0, update_valid = 1'b0, update_taken = 1'b0;
    logic [DW-1:0] lookup_pc = '0, update_pc = '0, update_trgt = '0;
    logic          pred_valid, pred_hit, pred_taken, ready;
    logic [DW-1:0] pred_trgt;

    branch_predictor #(.DATA_WIDTH(DW), .SETS(SETS), .WAYS(WAYS), .CTR_BITS(CB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_trgt(pred_trgt),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_trgt(update_trgt),
        .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            v;
        bit            h;
        bit            t;
        bit            rdy;
        logic [DW-1:0] trgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: each set is a list of WAYS slots plus a replacement cursor.
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int unsigned m_trgt  [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    int          m_vict  [SETS];
    int          sweep_left = 0;
    bit          last_h = 0, last_t = 0;
    logic [DW-1:0] last_trgt = '0;

    function automatic int set_of(input logic [DW-1:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [DW-1:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic int find_way(input logic [DW-1:0] pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set_of(pc)][w] && m_tag[set_of(pc)][w] == tag_of(pc)) return w;
        return -1;
    endfunction

    task automatic model_update(input logic [DW-1:0] pc, input bit tk, input logic [DW-1:0] tg);
        int s, w;
        s = set_of(pc);
        w = find_way(pc);
        if (w >= 0) begin
            if (tk) begin
                m_ctr[s][w]  = (m_ctr[s][w] < CMAX) ? m_ctr[s][w] + 1 : CMAX;
                m_trgt[s][w] = tg;
            end else begin
                m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
            end
        end else if (tk) begin
            w = -1;
            for (int i = 0; i < WAYS; i++)
                if (w < 0 && !m_valid[s][i]) w = i;
            if (w < 0) begin
                w = m_vict[s];
                m_vict[s] = (m_vict[s] + 1) % WAYS;
            end
            m_valid[s][w] = 1;
            m_tag[s][w]   = tag_of(pc);
            m_trgt[s][w]  = tg;
            m_ctr[s][w]   = 1 << (CB - 1);
        end
    endtask

    task automatic step(input bit r, input bit f, input bit lv, input logic [DW-1:0] lpc,
                        input bit uv, input logic [DW-1:0] upc, input bit ut,
                        input logic [DW-1:0] utr);
        exp_t e;
        bit   running;
        int   w;
        @(negedge clk);
        rst = r; flush = f;
        lookup_valid = lv; lookup_pc = lpc;
        update_valid = uv; update_pc = upc; update_taken = ut; update_trgt = utr;
        running = (sweep_left == 0);
        e.v = 0;
        if (r) begin
            last_h = 0; last_t = 0; last_trgt = '0;
        end else if (running && !f && lv) begin
            e.v = 1;
            w = find_way(lpc);
            last_h    = (w >= 0);
            last_t    = (w >= 0) && (m_ctr[set_of(lpc)][w] >= (1 << (CB - 1)));
            last_trgt = (w >= 0) ? m_trgt[set_of(lpc)][w] : '0;
        end
        e.h = last_h; e.t = last_t; e.trgt = last_trgt;
        if (!r && !f && running && uv) model_update(upc, ut, utr);
        if (r || f) begin
            for (int s = 0; s < SETS; s++) begin
                m_vict[s] = 0;
                for (int i = 0; i < WAYS; i++) m_valid[s][i] = 0;
            end
            sweep_left = SETS;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end
        e.rdy = (sweep_left == 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic look(input logic [DW-1:0] pc);
        step(0, 0, 1, pc, 0, '0, 0, '0);
    endtask

    task automatic upd(input logic [DW-1:0] pc, input bit tk, input logic [DW-1:0] tg);
        step(0, 0, 0, '0, 1, pc, tk, tg);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ready", DW'(ready), DW'(e.rdy));
                check("pred_valid", DW'(pred_valid), DW'(e.v));
                check("pred_hit", DW'(pred_hit), DW'(e.h));
                check("pred_taken", DW'(pred_taken), DW'(e.t));
                check("pred_trgt", pred_trgt, e.trgt);
                if (e.v)
                    $display("lookup pc=%0h hit=%0b taken=%0b trgt=%0h", lookup_pc, pred_hit,
                             pred_taken, pred_trgt);
            end
        end
    end

    initial begin : driver
        logic [DW-1:0] pa, pb;
        step(1, 0, 0, '0, 0, '0, 0, '0);
        step(1, 0, 0, '0, 0, '0, 0, '0);
        idle(16);
        look(32'h100);
        upd(32'h100, 1, 32'h400);
        look(32'h100);
        upd(32'h100, 0, 32'h0);
        upd(32'h100, 0, 32'h0);
        look(32'h100);
        for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h400);
        upd(32'h100, 0, 32'h0);
        look(32'h100);
        upd(32'h040, 1, 32'h1040);
        upd(32'h080, 1, 32'h1080);
        upd(32'h0C0, 1, 32'h10C0);
        look(32'h040);
        look(32'h080);
        look(32'h0C0);
        step(0, 0, 1, 32'h200, 1, 32'h200, 1, 32'h2200);
        look(32'h200);
        upd(32'h300, 0, 32'h3300);
        look(32'h300);
        step(0, 1, 1, 32'h080, 0, '0, 0, '0);
        idle(5);
        step(0, 1, 0, '0, 0, '0, 0, '0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 32'h080, 1, 32'h080, 1, 32'h5);
        look(32'h080);
        look(32'h0C0);
        look(32'h200);
        for (int i = 0; i < 2000; i++) begin
            pa = (DW'($urandom_range(0, 7)) << 6) | (DW'($urandom_range(0, 3)) << 2)
                 | DW'($urandom_range(0, 3));
            pb = (DW'($urandom_range(0, 7)) << 6) | (DW'($urandom_range(0, 3)) << 2)
                 | DW'($urandom_range(0, 3));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), pa,
                 ($urandom_range(0, 1) == 1), pb, ($urandom_range(0, 2) != 0),
                 DW'($urandom) & 32'hFFFF_FFFC);
        end
        idle(3);
        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
